// File: rtl/regfile_scoreboard.sv
// Register file with a per-entry busy scoreboard: registered two-port read,
// single writeback port, and an issue port that reserves destinations.
module regfile_scoreboard #(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_SIZE = 5,
    parameter int ZERO_REG  = 1,
    parameter int BYPASS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 read_reg,
    input  logic [ADDR_SIZE-1:0] rs1_addr,
    input  logic [ADDR_SIZE-1:0] rs2_addr,
    input  logic                 write_reg,
    input  logic [ADDR_SIZE-1:0] rd_addr,
    input  logic [DATA_SIZE-1:0] write_data,
    input  logic                 issue_valid,
    input  logic [ADDR_SIZE-1:0] issue_addr,
    output logic [DATA_SIZE-1:0] rs1_data,
    output logic [DATA_SIZE-1:0] rs2_data,
    output logic                 rs1_busy,
    output logic                 rs2_busy,
    output logic [ADDR_SIZE:0]   busy_count
);
    localparam int DEPTH = 2 ** ADDR_SIZE;

    logic [DATA_SIZE-1:0] regs [DEPTH];
    logic [DEPTH-1:0]     busy;
    logic [DEPTH-1:0]     busy_next;
    logic [ADDR_SIZE:0]   count_next;
    logic                 wr_en;
    logic                 set_en;
    logic [DATA_SIZE-1:0] rs1_next;
    logic [DATA_SIZE-1:0] rs2_next;

    assign wr_en  = write_reg   && !(ZERO_REG != 0 && rd_addr == '0);
    assign set_en = issue_valid && !(ZERO_REG != 0 && issue_addr == '0);

    // Set is applied after clear so a same-cycle reservation of the
    // writeback destination leaves it busy.
    always_comb begin
        busy_next = busy;
        if (write_reg) busy_next[rd_addr] = 1'b0;
        if (set_en)    busy_next[issue_addr] = 1'b1;
        count_next = '0;
        for (int i = 0; i < DEPTH; i++)
            count_next = count_next + {{ADDR_SIZE{1'b0}}, busy_next[i]};
    end

    always_comb begin
        rs1_next = regs[rs1_addr];
        rs2_next = regs[rs2_addr];
        if (BYPASS != 0 && wr_en && rd_addr == rs1_addr) rs1_next = write_data;
        if (BYPASS != 0 && wr_en && rd_addr == rs2_addr) rs2_next = write_data;
        if (ZERO_REG != 0 && rs1_addr == '0) rs1_next = '0;
        if (ZERO_REG != 0 && rs2_addr == '0) rs2_next = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
            busy       <= '0;
            busy_count <= '0;
            rs1_data   <= '0;
            rs2_data   <= '0;
            rs1_busy   <= 1'b0;
            rs2_busy   <= 1'b0;
        end else begin
            if (wr_en) regs[rd_addr] <= write_data;
            busy       <= busy_next;
            busy_count <= count_next;
            if (read_reg) begin
                rs1_data <= rs1_next;
                rs2_data <= rs2_next;
                rs1_busy <= busy_next[rs1_addr];
                rs2_busy <= busy_next[rs2_addr];
            end
        end
    end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed + random bench for regfile_scoreboard; expectations come from a
// behavioural model and are queued at drive time, popped after the edge.
module tb_regfile_scoreboard;
    logic        clk = 1'b0;
    logic        rst;
    logic        read_reg;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr, issue_addr;
    logic        write_reg, issue_valid;
    logic [31:0] write_data;
    logic [31:0] rs1_data, rs2_data, nb_rs1_data, nb_rs2_data;
    logic        rs1_busy, rs2_busy, nb_rs1_busy, nb_rs2_busy;
    logic [5:0]  busy_count, nb_busy_count;

    always #5 clk = ~clk;

    regfile_scoreboard u_dut (
        .clk(clk), .rst(rst), .read_reg(read_reg),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .write_reg(write_reg), .rd_addr(rd_addr), .write_data(write_data),
        .issue_valid(issue_valid), .issue_addr(issue_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .busy_count(busy_count)
    );

    regfile_scoreboard #(.BYPASS(0)) u_nb (
        .clk(clk), .rst(rst), .read_reg(read_reg),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .write_reg(write_reg), .rd_addr(rd_addr), .write_data(write_data),
        .issue_valid(issue_valid), .issue_addr(issue_addr),
        .rs1_data(nb_rs1_data), .rs2_data(nb_rs2_data),
        .rs1_busy(nb_rs1_busy), .rs2_busy(nb_rs2_busy), .busy_count(nb_busy_count)
    );

    typedef struct {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        b1;
        logic        b2;
        logic [5:0]  cnt;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_regs [32];
    logic [31:0] m_busy;
    exp_t        m_out;
    int          compared = 0;
    int          mismatched = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic rr, input logic [4:0] a1, input logic [4:0] a2,
                        input logic wr, input logic [4:0] rd, input logic [31:0] wd,
                        input logic iv, input logic [4:0] ia, input string tag);
        logic [31:0] bn;
        logic        we;
        exp_t        e;
        rst = r; read_reg = rr; rs1_addr = a1; rs2_addr = a2;
        write_reg = wr; rd_addr = rd; write_data = wd; issue_valid = iv; issue_addr = ia;
        if (r) begin
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
            m_busy = '0;
            m_out = '{32'h0, 32'h0, 1'b0, 1'b0, 6'd0};
        end else begin
            we = wr && rd != 5'd0;
            bn = m_busy;
            if (wr) bn[rd] = 1'b0;
            if (iv && ia != 5'd0) bn[ia] = 1'b1;
            if (rr) begin
                m_out.rs1 = (a1 == 5'd0) ? 32'h0 : (we && rd == a1) ? wd : m_regs[a1];
                m_out.rs2 = (a2 == 5'd0) ? 32'h0 : (we && rd == a2) ? wd : m_regs[a2];
                m_out.b1  = bn[a1];
                m_out.b2  = bn[a2];
            end
            if (we) m_regs[rd] = wd;
            m_busy = bn;
            m_out.cnt = 6'($countones(bn));
        end
        sb.push_back(m_out);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({tag, ".rs1_data"}, rs1_data, e.rs1);
        check({tag, ".rs2_data"}, rs2_data, e.rs2);
        check({tag, ".rs1_busy"}, {31'b0, rs1_busy}, {31'b0, e.b1});
        check({tag, ".rs2_busy"}, {31'b0, rs2_busy}, {31'b0, e.b2});
        check({tag, ".busy_count"}, {26'b0, busy_count}, {26'b0, e.cnt});
    endtask

    task automatic idle_read(input logic [4:0] a1, input logic [4:0] a2, input string tag);
        step(1'b0, 1'b1, a1, a2, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, tag);
    endtask

    initial begin
        // reset
        step(1'b1, 1'b1, 5'd1, 5'd2, 1'b1, 5'd1, 32'hFFFF, 1'b1, 5'd1, "reset0");
        step(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, "reset1");
        check("reset.count_const", {26'b0, busy_count}, 32'd0);

        // basic write then read
        step(1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, "wr5");
        idle_read(5'd5, 5'd6, "rd5");
        check("rd5.const", rs1_data, 32'hDEADBEEF);

        // entry 0 is hardwired
        step(1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 32'h1234, 1'b1, 5'd0, "zero_wr");
        idle_read(5'd0, 5'd0, "zero_rd");
        check("zero.data_const", rs1_data, 32'h0);
        check("zero.count_const", {26'b0, busy_count}, 32'd0);

        // bypass vs no-bypass instance
        step(1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd7, 32'h11111111, 1'b0, 5'd0, "wr7");
        step(1'b0, 1'b1, 5'd1, 5'd7, 1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, "byp7");
        check("byp7.bypass_const", rs2_data, 32'hA5A5A5A5);
        check("byp7.nobypass_const", nb_rs2_data, 32'h11111111);

        // busy set and clear
        step(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, "iss3");
        step(1'b0, 1'b1, 5'd3, 5'd4, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, "iss4");
        check("iss4.count_const", {26'b0, busy_count}, 32'd2);
        check("iss4.busy3_const", {31'b0, rs1_busy}, 32'd1);
        step(1'b0, 1'b1, 5'd3, 5'd4, 1'b1, 5'd3, 32'h33, 1'b0, 5'd0, "wb3");
        check("wb3.count_const", {26'b0, busy_count}, 32'd1);
        check("wb3.busy3_const", {31'b0, rs1_busy}, 32'd0);

        // same-cycle set and clear of entry 9
        step(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, "iss9");
        step(1'b0, 1'b1, 5'd9, 5'd9, 1'b1, 5'd9, 32'h99, 1'b1, 5'd9, "setclr9");
        check("setclr9.count_const", {26'b0, busy_count}, 32'd2);
        check("setclr9.busy_const", {31'b0, rs1_busy}, 32'd1);
        idle_read(5'd9, 5'd5, "rd9");
        check("rd9.data_const", rs1_data, 32'h99);

        // hold when read_reg is low
        step(1'b0, 1'b0, 5'd5, 5'd3, 1'b1, 5'd12, 32'hC0FFEE, 1'b0, 5'd0, "hold");
        check("hold.rs1_const", rs1_data, 32'h99);

        // random traffic against the model
        for (int i = 0; i < 40; i++)
            step(1'b0, 1'($urandom_range(0, 1)), 5'($urandom), 5'($urandom),
                 1'($urandom_range(0, 1)), 5'($urandom), $urandom,
                 1'($urandom_range(0, 1)), 5'($urandom), "rand");

        // fill the scoreboard, then reset mid-stream
        for (int a = 1; a < 32; a++)
            step(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'(a), "fill");
        check("fill.count_const", {26'b0, busy_count}, 32'd31);
        step(1'b1, 1'b1, 5'd5, 5'd9, 1'b1, 5'd5, 32'h5555, 1'b1, 5'd6, "midrst");
        idle_read(5'd5, 5'd9, "postrst");
        check("postrst.rs1_const", rs1_data, 32'h0);
        check("postrst.count_const", {26'b0, busy_count}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
